stun_controller: RTL

Parametrised successor to the two-player stun detector: compares each player's board cell against a list of bomb-blast cells and runs a per-player stun / immunity timer, so players recover after a fixed time. Supports any number of players, a variable-length blast list with per-entry valid mask, and a selectable re-hit policy. It sits between the bomb/explosion logic, which supplies the blast cells, and the player movement FSMs, which freeze while `stun_en` is high.

---
 rtl/stun_pkg.sv | 26 ++
 rtl/stun_channel.sv | 119 +++++++++++
 rtl/stun_controller.sv | 46 ++++
 3 files changed

// File: rtl/stun_pkg.sv
// Shared types and constants for the stun controller.
// Holds the channel FSM states, cell index type and the counter-width helper.
package stun_pkg;

    localparam int CELL_W_DEFAULT = 9;
    localparam int HIT_CNT_W      = 8;
    localparam logic [HIT_CNT_W-1:0] HIT_CNT_MAX = 8'd255;

    typedef logic [CELL_W_DEFAULT-1:0] cell_t;

    typedef enum logic [1:0] {
        READY   = 2'd0,
        STUNNED = 2'd1,
        IMMUNE  = 2'd2
    } stun_state_t;

    // Width large enough to hold the larger of the two period reloads.
    function automatic int stun_cnt_width(input int stun_cycles, input int immune_cycles);
        int m;
        m = 2;
        if (stun_cycles > m) m = stun_cycles;
        if (immune_cycles > m) m = immune_cycles;
        return $clog2(m);
    endfunction

endpackage

// File: rtl/stun_channel.sv
// One player channel: blast hit compare, READY/STUNNED/IMMUNE timer FSM and a
// saturating hit counter. All outputs come straight from flops.
module stun_channel
    import stun_pkg::*;
#(
    parameter int NUM_BLAST     = 10,
    parameter int CELL_W        = 9,
    parameter int STUN_CYCLES   = 50_000_000,
    parameter int IMMUNE_CYCLES = 25_000_000,
    parameter int EXTEND_ON_HIT = 0
) (
    input  logic                        i_clk,
    input  logic                        i_resetn,
    input  logic                        i_blast_valid,
    input  logic [NUM_BLAST*CELL_W-1:0] i_blast_cells,
    input  logic [NUM_BLAST-1:0]        i_blast_mask,
    input  logic [CELL_W-1:0]           i_player_cell,
    output logic                        o_stun_en,
    output logic                        o_immune,
    output logic                        o_stun_start,
    output logic [HIT_CNT_W-1:0]        o_hit_count
);

    localparam int CNT_W = stun_cnt_width(STUN_CYCLES, IMMUNE_CYCLES);
    localparam logic [CNT_W-1:0] STUN_LOAD   = CNT_W'(STUN_CYCLES - 1);
    localparam logic [CNT_W-1:0] IMMUNE_LOAD =
        (IMMUNE_CYCLES > 0) ? CNT_W'(IMMUNE_CYCLES - 1) : '0;

    stun_state_t            r_state;
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_stun_en;
    logic                   r_immune;
    logic                   r_stun_start;
    logic [HIT_CNT_W-1:0]   r_hit_count;

    logic                   w_hit;
    logic                   w_accept;
    stun_state_t            w_state_nxt;
    logic [CNT_W-1:0]       w_cnt_nxt;

    always_comb begin
        w_hit = 1'b0;
        for (int i = 0; i < NUM_BLAST; i++) begin
            if (i_blast_mask[i] && (i_blast_cells[i*CELL_W +: CELL_W] == i_player_cell)) begin
                w_hit = 1'b1;
            end
        end
        w_hit = w_hit & i_blast_valid;
    end

    // A reload while stunned takes priority over the expiry of the stun period.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_accept    = 1'b0;
        case (r_state)
            READY: begin
                if (w_hit) begin
                    w_accept    = 1'b1;
                    w_state_nxt = STUNNED;
                    w_cnt_nxt   = STUN_LOAD;
                end
            end
            STUNNED: begin
                if (w_hit && (EXTEND_ON_HIT != 0)) begin
                    w_accept  = 1'b1;
                    w_cnt_nxt = STUN_LOAD;
                end else if (r_cnt == '0) begin
                    if (IMMUNE_CYCLES == 0) begin
                        w_state_nxt = READY;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_state_nxt = IMMUNE;
                        w_cnt_nxt   = IMMUNE_LOAD;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            IMMUNE: begin
                if (r_cnt == '0) begin
                    w_state_nxt = READY;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            default: begin
                w_state_nxt = READY;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_resetn) begin
            r_state      <= READY;
            r_cnt        <= '0;
            r_stun_en    <= 1'b0;
            r_immune     <= 1'b0;
            r_stun_start <= 1'b0;
            r_hit_count  <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_stun_en    <= (w_state_nxt == STUNNED);
            r_immune     <= (w_state_nxt == IMMUNE);
            r_stun_start <= w_accept;
            if (w_accept && (r_hit_count != HIT_CNT_MAX)) begin
                r_hit_count <= r_hit_count + 8'd1;
            end
        end
    end

    assign o_stun_en    = r_stun_en;
    assign o_immune     = r_immune;
    assign o_stun_start = r_stun_start;
    assign o_hit_count  = r_hit_count;

endmodule

// File: rtl/stun_controller.sv
// Multi-player stun controller: one independent stun_channel per player, all
// sharing the explosion blast bus.
module stun_controller
    import stun_pkg::*;
#(
    parameter int NUM_PLAYERS   = 2,
    parameter int NUM_BLAST     = 10,
    parameter int CELL_W        = 9,
    parameter int STUN_CYCLES   = 50_000_000,
    parameter int IMMUNE_CYCLES = 25_000_000,
    parameter int EXTEND_ON_HIT = 0
) (
    input  logic                            i_clk,
    input  logic                            i_resetn,
    input  logic                            i_blast_valid,
    input  logic [NUM_BLAST*CELL_W-1:0]     i_blast_cells,
    input  logic [NUM_BLAST-1:0]            i_blast_mask,
    input  logic [NUM_PLAYERS*CELL_W-1:0]   i_player_cells,
    output logic [NUM_PLAYERS-1:0]          o_stun_en,
    output logic [NUM_PLAYERS-1:0]          o_immune,
    output logic [NUM_PLAYERS-1:0]          o_stun_start,
    output logic [NUM_PLAYERS*HIT_CNT_W-1:0] o_hit_count
);

    for (genvar g = 0; g < NUM_PLAYERS; g++) begin : g_player
        stun_channel #(
            .NUM_BLAST     (NUM_BLAST),
            .CELL_W        (CELL_W),
            .STUN_CYCLES   (STUN_CYCLES),
            .IMMUNE_CYCLES (IMMUNE_CYCLES),
            .EXTEND_ON_HIT (EXTEND_ON_HIT)
        ) u_channel (
            .i_clk         (i_clk),
            .i_resetn      (i_resetn),
            .i_blast_valid (i_blast_valid),
            .i_blast_cells (i_blast_cells),
            .i_blast_mask  (i_blast_mask),
            .i_player_cell (i_player_cells[g*CELL_W +: CELL_W]),
            .o_stun_en     (o_stun_en[g]),
            .o_immune      (o_immune[g]),
            .o_stun_start  (o_stun_start[g]),
            .o_hit_count   (o_hit_count[g*HIT_CNT_W +: HIT_CNT_W])
        );
    end

endmodule
